seq_divider: RTL

//  Sequential restoring divider: the inverse of the 8x8 combinational multiplier.

---
 rtl/seq_divider.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// Sequential restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor, one quotient bit per clock.
// Optional two's-complement operation when DIV_SIGNED_EN is defined.
module seq_divider #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [2*WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0]   i_divisor,
    output logic [WIDTH-1:0]   o_quotient,
    output logic [WIDTH-1:0]   o_remainder,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_div_zero,
    output logic               o_overflow
);

    localparam int unsigned DW = 2 * WIDTH;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [WIDTH-1:0]  r_dvsr;
    logic [WIDTH-1:0]  r_part;
    logic [WIDTH-1:0]  r_shift;

    logic [DW-1:0]     w_dvd_mag;
    logic [WIDTH-1:0]  w_dvs_mag;
    logic [WIDTH:0]    w_trial;
    logic              w_ge;
    logic [WIDTH-1:0]  w_diff;
    logic [WIDTH-1:0]  w_part_nx;
    logic [WIDTH-1:0]  w_shift_nx;
    logic [WIDTH-1:0]  w_q_fin;
    logic [WIDTH-1:0]  w_r_fin;
    logic              w_q_ovf;

    // One restoring step: shift the next dividend bit into P, subtract if it fits.
    // r_shift holds the unconsumed dividend bits and collects quotient bits at its LSB.
    assign w_trial    = {r_part, r_shift[WIDTH-1]};
    assign w_ge       = (w_trial >= {1'b0, r_dvsr});
    assign w_diff     = WIDTH'(w_trial - {1'b0, r_dvsr});
    assign w_part_nx  = w_ge ? w_diff : w_trial[WIDTH-1:0];
    assign w_shift_nx = {r_shift[WIDTH-2:0], w_ge};

`ifdef DIV_SIGNED_EN
    logic              r_q_neg;
    logic              r_r_neg;
    logic              w_dvd_neg;
    logic              w_dvs_neg;
    logic [WIDTH-1:0]  w_q_lim;

    assign w_dvd_neg = i_dividend[DW-1];
    assign w_dvs_neg = i_divisor[WIDTH-1];
    assign w_dvd_mag = w_dvd_neg ? DW'(~i_dividend + DW'(1)) : i_dividend;
    assign w_dvs_mag = w_dvs_neg ? WIDTH'(~i_divisor + WIDTH'(1)) : i_divisor;

    // Negative quotients may reach -2^(W-1); positive ones stop at 2^(W-1)-1.
    assign w_q_lim = WIDTH'(1) << (WIDTH - 1);
    assign w_q_ovf = r_q_neg ? (w_shift_nx > w_q_lim) : (w_shift_nx >= w_q_lim);
    assign w_q_fin = r_q_neg ? WIDTH'(~w_shift_nx + WIDTH'(1)) : w_shift_nx;
    assign w_r_fin = r_r_neg ? WIDTH'(~w_part_nx + WIDTH'(1)) : w_part_nx;
`else
    assign w_dvd_mag = i_dividend;
    assign w_dvs_mag = i_divisor;
    assign w_q_ovf   = 1'b0;
    assign w_q_fin   = w_shift_nx;
    assign w_r_fin   = w_part_nx;
`endif

    // Control FSM, datapath and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_dvsr      <= '0;
            r_part      <= '0;
            r_shift     <= '0;
            o_quotient  <= '0;
            o_remainder <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_div_zero  <= 1'b0;
            o_overflow  <= 1'b0;
`ifdef DIV_SIGNED_EN
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_dvsr      <= w_dvs_mag;
                        r_part      <= w_dvd_mag[DW-1:WIDTH];
                        r_shift     <= w_dvd_mag[WIDTH-1:0];
                        r_cnt       <= '0;
                        o_quotient  <= '0;
                        o_remainder <= '0;
                        o_busy      <= 1'b1;
`ifdef DIV_SIGNED_EN
                        r_q_neg     <= w_dvd_neg ^ w_dvs_neg;
                        r_r_neg     <= w_dvd_neg;
`endif
                        if (w_dvs_mag == '0) begin
                            o_div_zero <= 1'b1;
                            o_overflow <= 1'b0;
                            o_done     <= 1'b1;
                            r_state    <= S_DONE;
                        end else if (w_dvd_mag[DW-1:WIDTH] >= w_dvs_mag) begin
                            o_div_zero <= 1'b0;
                            o_overflow <= 1'b1;
                            o_done     <= 1'b1;
                            r_state    <= S_DONE;
                        end else begin
                            o_div_zero <= 1'b0;
                            o_overflow <= 1'b0;
                            r_state    <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_part  <= w_part_nx;
                    r_shift <= w_shift_nx;
                    r_cnt   <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        o_done  <= 1'b1;
                        r_state <= S_DONE;
                        if (w_q_ovf) begin
                            o_overflow <= 1'b1;
                        end else begin
                            o_quotient  <= w_q_fin;
                            o_remainder <= w_r_fin;
                        end
                    end
                end
                S_DONE: begin
                    o_busy  <= 1'b0;
                    o_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    o_busy  <= 1'b0;
                    o_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
